// File: rtl/parking_pkg.sv
// Shared types and sizes for the 4-slot parking gate controller.
package parking_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SLOT_W    = 2;

    typedef logic [SLOT_W-1:0]    slot_t;
    typedef logic [NUM_SLOTS-1:0] occ_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ENTRY_GATE = 3'd1,
        ST_EXIT_BILL  = 3'd2,
        ST_EXIT_PAY   = 3'd3,
        ST_EXIT_GATE  = 3'd4
    } state_e;

endpackage

// File: rtl/slot_alloc_pe.sv
// Lowest-free-slot priority encoder over the occupancy vector.
module slot_alloc_pe
    import parking_pkg::*;
(
    input  occ_t  occ,
    output slot_t free_idx,
    output logic  none_free
);

    // Scan from the top so the lowest free index is the last one written.
    always_comb begin
        free_idx  = '0;
        none_free = 1'b1;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                free_idx  = SLOT_W'(i);
                none_free = 1'b0;
            end
        end
    end

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit barrier sequencer: slot allocation, exit validation, billing handshake.
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 16,
    parameter int unsigned PAY_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [1:0] exit_req_slot,
    input  logic       pay_ok,
    output logic [3:0] occupancy,
    output logic       exit_pulse,
    output logic [1:0] exit_slot,
    output logic       entry_grant,
    output logic [1:0] entry_slot,
    output logic       entry_reject,
    output logic       exit_reject,
    output logic       gate_in_open,
    output logic       gate_out_open,
    output logic       full,
    output logic       busy
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int unsigned PAY_W  = $clog2(PAY_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              entry_pend_q, entry_pend_d;
    logic              exit_pend_q, exit_pend_d;
    slot_t             req_slot_q, req_slot_d;
    logic              prio_exit_q, prio_exit_d;
    occ_t              occ_q, occ_d;
    slot_t             entry_slot_q, entry_slot_d;
    slot_t             exit_slot_q, exit_slot_d;
    logic              entry_grant_q, entry_grant_d;
    logic              entry_reject_q, entry_reject_d;
    logic              exit_pulse_q, exit_pulse_d;
    logic              exit_reject_q, exit_reject_d;
    logic              gate_in_q, gate_in_d;
    logic              gate_out_q, gate_out_d;
    logic [GATE_W-1:0] gate_tmr_q, gate_tmr_d;
    logic [PAY_W-1:0]  pay_tmr_q, pay_tmr_d;

    slot_t free_idx;
    logic  none_free;
    logic  serve_entry, serve_exit;

    slot_alloc_pe u_alloc (
        .occ       (occ_q),
        .free_idx  (free_idx),
        .none_free (none_free)
    );

    always_comb begin
        state_d        = state_q;
        entry_pend_d   = entry_pend_q;
        exit_pend_d    = exit_pend_q;
        req_slot_d     = req_slot_q;
        prio_exit_d    = prio_exit_q;
        occ_d          = occ_q;
        entry_slot_d   = entry_slot_q;
        exit_slot_d    = exit_slot_q;
        entry_grant_d  = 1'b0;
        entry_reject_d = 1'b0;
        exit_pulse_d   = 1'b0;
        exit_reject_d  = 1'b0;
        gate_in_d      = gate_in_q;
        gate_out_d     = gate_out_q;
        gate_tmr_d     = gate_tmr_q;
        pay_tmr_d      = pay_tmr_q;
        serve_entry    = 1'b0;
        serve_exit     = 1'b0;

        // The fairness toggle only moves when both sides are contending.
        if (state_q == ST_IDLE) begin
            if (entry_pend_q && exit_pend_q) begin
                serve_exit  = prio_exit_q;
                serve_entry = !prio_exit_q;
                prio_exit_d = !prio_exit_q;
            end else begin
                serve_entry = entry_pend_q;
                serve_exit  = exit_pend_q;
            end
        end

        if (serve_entry) entry_pend_d = 1'b0;
        if (serve_exit)  exit_pend_d  = 1'b0;
        if (!entry_pend_q && entry_req) entry_pend_d = 1'b1;
        if (!exit_pend_q && exit_req) begin
            exit_pend_d = 1'b1;
            req_slot_d  = exit_req_slot;
        end

        case (state_q)
            ST_IDLE: begin
                if (serve_entry) begin
                    if (none_free) begin
                        entry_reject_d = 1'b1;
                    end else begin
                        occ_d[free_idx] = 1'b1;
                        entry_slot_d    = free_idx;
                        entry_grant_d   = 1'b1;
                        gate_in_d       = 1'b1;
                        gate_tmr_d      = GATE_W'(GATE_CYCLES);
                        state_d         = ST_ENTRY_GATE;
                    end
                end else if (serve_exit) begin
                    if (!occ_q[req_slot_q]) begin
                        exit_reject_d = 1'b1;
                    end else begin
                        exit_slot_d  = req_slot_q;
                        exit_pulse_d = 1'b1;
                        state_d      = ST_EXIT_BILL;
                    end
                end
            end
            ST_ENTRY_GATE: begin
                if (gate_tmr_q == GATE_W'(1)) begin
                    gate_in_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    gate_tmr_d = gate_tmr_q - GATE_W'(1);
                end
            end
            ST_EXIT_BILL: begin
                pay_tmr_d = PAY_W'(PAY_TIMEOUT);
                state_d   = ST_EXIT_PAY;
            end
            ST_EXIT_PAY: begin
                if (pay_ok) begin
                    occ_d[exit_slot_q] = 1'b0;
                    gate_out_d         = 1'b1;
                    gate_tmr_d         = GATE_W'(GATE_CYCLES);
                    state_d            = ST_EXIT_GATE;
                end else if (pay_tmr_q == PAY_W'(1)) begin
                    exit_reject_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    pay_tmr_d = pay_tmr_q - PAY_W'(1);
                end
            end
            ST_EXIT_GATE: begin
                if (gate_tmr_q == GATE_W'(1)) begin
                    gate_out_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    gate_tmr_d = gate_tmr_q - GATE_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            entry_pend_q   <= 1'b0;
            exit_pend_q    <= 1'b0;
            req_slot_q     <= '0;
            prio_exit_q    <= 1'b1;
            occ_q          <= '0;
            entry_slot_q   <= '0;
            exit_slot_q    <= '0;
            entry_grant_q  <= 1'b0;
            entry_reject_q <= 1'b0;
            exit_pulse_q   <= 1'b0;
            exit_reject_q  <= 1'b0;
            gate_in_q      <= 1'b0;
            gate_out_q     <= 1'b0;
            gate_tmr_q     <= '0;
            pay_tmr_q      <= '0;
        end else begin
            state_q        <= state_d;
            entry_pend_q   <= entry_pend_d;
            exit_pend_q    <= exit_pend_d;
            req_slot_q     <= req_slot_d;
            prio_exit_q    <= prio_exit_d;
            occ_q          <= occ_d;
            entry_slot_q   <= entry_slot_d;
            exit_slot_q    <= exit_slot_d;
            entry_grant_q  <= entry_grant_d;
            entry_reject_q <= entry_reject_d;
            exit_pulse_q   <= exit_pulse_d;
            exit_reject_q  <= exit_reject_d;
            gate_in_q      <= gate_in_d;
            gate_out_q     <= gate_out_d;
            gate_tmr_q     <= gate_tmr_d;
            pay_tmr_q      <= pay_tmr_d;
        end
    end

    assign occupancy     = occ_q;
    assign exit_pulse    = exit_pulse_q;
    assign exit_slot     = exit_slot_q;
    assign entry_grant   = entry_grant_q;
    assign entry_slot    = entry_slot_q;
    assign entry_reject  = entry_reject_q;
    assign exit_reject   = exit_reject_q;
    assign gate_in_open  = gate_in_q;
    assign gate_out_open = gate_out_q;
    assign full          = &occ_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller with a per-cycle behavioural model.
module tb_parking_gate_controller;

    localparam int unsigned G = 16;
    localparam int unsigned P = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [1:0] exit_req_slot = 2'd0;
    logic       pay_ok = 1'b0;
    logic [3:0] occupancy;
    logic       exit_pulse;
    logic [1:0] exit_slot;
    logic       entry_grant;
    logic [1:0] entry_slot;
    logic       entry_reject;
    logic       exit_reject;
    logic       gate_in_open;
    logic       gate_out_open;
    logic       full;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parking_gate_controller #(.GATE_CYCLES(G), .PAY_TIMEOUT(P)) dut (
        .clk           (clk),
        .rst           (rst),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_req_slot (exit_req_slot),
        .pay_ok        (pay_ok),
        .occupancy     (occupancy),
        .exit_pulse    (exit_pulse),
        .exit_slot     (exit_slot),
        .entry_grant   (entry_grant),
        .entry_slot    (entry_slot),
        .entry_reject  (entry_reject),
        .exit_reject   (exit_reject),
        .gate_in_open  (gate_in_open),
        .gate_out_open (gate_out_open),
        .full          (full),
        .busy          (busy)
    );

    // Model: lot contents, waiting requests and the remaining cycles of each transaction phase.
    typedef struct packed {
        logic [3:0] occ;
        logic       epend;
        logic       xpend;
        logic       prio_exit;
        logic [1:0] rslot;
        logic [7:0] in_left;
        logic [7:0] out_left;
        logic [7:0] pay_left;
        logic       bill;
        logic       grant;
        logic       ereject;
        logic       pulse;
        logic       xreject;
        logic [1:0] eslot;
        logic [1:0] xslot;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.prio_exit = 1'b1;
        return r;
    endfunction

    function automatic model_t model_step(model_t s, logic e_req, logic x_req,
                                          logic [1:0] x_slot, logic pay);
        model_t n;
        logic se;
        logic sx;
        logic found;
        logic [1:0] lowest;
        n = s;
        n.grant = 1'b0; n.ereject = 1'b0; n.pulse = 1'b0; n.xreject = 1'b0;
        se = 1'b0; sx = 1'b0; found = 1'b0; lowest = 2'd0;
        if (s.in_left != 0) begin
            n.in_left = s.in_left - 8'd1;
        end else if (s.out_left != 0) begin
            n.out_left = s.out_left - 8'd1;
        end else if (s.bill) begin
            n.bill = 1'b0;
            n.pay_left = 8'(P);
        end else if (s.pay_left != 0) begin
            if (pay) begin
                n.occ[s.xslot] = 1'b0;
                n.pay_left = 8'd0;
                n.out_left = 8'(G);
            end else begin
                n.pay_left = s.pay_left - 8'd1;
                if (s.pay_left == 8'd1) n.xreject = 1'b1;
            end
        end else begin
            if (s.epend && s.xpend) begin
                if (s.prio_exit) sx = 1'b1; else se = 1'b1;
                n.prio_exit = !s.prio_exit;
            end else begin
                se = s.epend;
                sx = s.xpend;
            end
            if (se) begin
                n.epend = 1'b0;
                for (int i = 3; i >= 0; i--) begin
                    if (!s.occ[i]) begin
                        found = 1'b1;
                        lowest = 2'(i);
                    end
                end
                if (!found) begin
                    n.ereject = 1'b1;
                end else begin
                    n.occ[lowest] = 1'b1;
                    n.eslot = lowest;
                    n.grant = 1'b1;
                    n.in_left = 8'(G);
                end
            end
            if (sx) begin
                n.xpend = 1'b0;
                if (!s.occ[s.rslot]) begin
                    n.xreject = 1'b1;
                end else begin
                    n.xslot = s.rslot;
                    n.pulse = 1'b1;
                    n.bill = 1'b1;
                end
            end
        end
        if (!s.epend && e_req) n.epend = 1'b1;
        if (!s.xpend && x_req) begin
            n.xpend = 1'b1;
            n.rslot = x_slot;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m, entry_req, exit_req, exit_req_slot, pay_ok);
    end

    function automatic logic [16:0] exp_vec(model_t s);
        logic b;
        logic f;
        b = (s.in_left != 0) || (s.out_left != 0) || s.bill || (s.pay_left != 0);
        f = (s.occ == 4'hF);
        return {s.occ, f, b, s.grant, s.eslot, s.ereject, s.pulse, s.xslot, s.xreject,
                (s.in_left != 0), (s.out_left != 0)};
    endfunction

    function automatic logic [16:0] act_vec();
        return {occupancy, full, busy, entry_grant, entry_slot, entry_reject, exit_pulse,
                exit_slot, exit_reject, gate_in_open, gate_out_open};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output against the model.
    task automatic tick();
        logic [16:0] a;
        logic [16:0] e;
        @(negedge clk);
        if (!rst) begin
            a = act_vec();
            e = exp_vec(m);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL model_cmp: got %05h expected %05h at %0t", a, e, $time);
            end
        end
    endtask

    task automatic pulse_entry();
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
    endtask

    task automatic pulse_exit(input logic [1:0] s);
        exit_req = 1'b1;
        exit_req_slot = s;
        tick();
        exit_req = 1'b0;
    endtask

    task automatic pulse_both(input logic [1:0] s);
        entry_req = 1'b1;
        exit_req = 1'b1;
        exit_req_slot = s;
        tick();
        entry_req = 1'b0;
        exit_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_outs", 32'(act_vec()), 32'd0);
        rst = 1'b0;
        tick();

        // First entry: grant two edges after the request, slot 0, gate open G cycles.
        pulse_entry();
        tick();
        chk("t1_grant", 32'(entry_grant), 32'd1);
        chk("t1_slot", 32'(entry_slot), 32'd0);
        chk("t1_occ", 32'(occupancy), 32'h1);
        n = 0;
        while (gate_in_open && n < 40) begin
            n++;
            tick();
        end
        chk("t1_gate_in_len", 32'(n), 32'(G));

        // Exit for an empty slot is rejected without billing.
        pulse_exit(2'd3);
        tick();
        chk("t4_reject", 32'(exit_reject), 32'd1);
        chk("t4_no_pulse", 32'(exit_pulse), 32'd0);
        chk("t4_occ", 32'(occupancy), 32'h1);
        tick();

        // Fill the lot, then a fifth car is refused.
        for (int s = 1; s < 4; s++) begin
            pulse_entry();
            tick();
            chk("t2_grant", 32'(entry_grant), 32'd1);
            chk("t2_slot", 32'(entry_slot), 32'(s));
            wait_idle();
        end
        chk("t2_full", 32'(full), 32'd1);
        pulse_entry();
        tick();
        chk("t2_reject", 32'(entry_reject), 32'd1);
        chk("t2_no_grant", 32'(entry_grant), 32'd0);
        chk("t2_occ", 32'(occupancy), 32'hF);
        tick();

        // Paid exit of slot 2.
        pulse_exit(2'd2);
        tick();
        chk("t3_pulse", 32'(exit_pulse), 32'd1);
        chk("t3_slot", 32'(exit_slot), 32'd2);
        repeat (5) tick();
        pay_ok = 1'b1;
        tick();
        pay_ok = 1'b0;
        chk("t3_occ", 32'(occupancy), 32'hB);
        chk("t3_gate_out", 32'(gate_out_open), 32'd1);
        n = 0;
        while (gate_out_open && n < 40) begin
            n++;
            tick();
        end
        chk("t3_gate_out_len", 32'(n), 32'(G));

        // Tie-break: exit first after reset, the following tie goes to entry.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        pulse_entry();
        tick();
        chk("t5_slot0", 32'(entry_slot), 32'd0);
        wait_idle();
        pulse_both(2'd0);
        tick();
        chk("t5_exit_first", 32'(exit_pulse), 32'd1);
        chk("t5_no_grant", 32'(entry_grant), 32'd0);
        tick();
        pay_ok = 1'b1;
        tick();
        pay_ok = 1'b0;
        chk("t5_occ_freed", 32'(occupancy), 32'h0);
        n = 0;
        while (!entry_grant && n < 60) begin
            tick();
            n++;
        end
        chk("t5_late_grant", 32'(entry_grant), 32'd1);
        chk("t5_late_slot", 32'(entry_slot), 32'd0);
        wait_idle();
        pulse_both(2'd0);
        tick();
        chk("t5_entry_second", 32'(entry_grant), 32'd1);
        chk("t5_entry_slot1", 32'(entry_slot), 32'd1);
        chk("t5_no_pulse", 32'(exit_pulse), 32'd0);
        n = 0;
        while (!exit_pulse && n < 60) begin
            tick();
            n++;
        end
        chk("t5_late_pulse", 32'(exit_pulse), 32'd1);
        chk("t5_late_xslot", 32'(exit_slot), 32'd0);
        tick();
        pay_ok = 1'b1;
        tick();
        pay_ok = 1'b0;
        wait_idle();
        chk("t5_occ_end", 32'(occupancy), 32'h2);

        // Payment timeout keeps the car; then reset during an open exit gate.
        pulse_exit(2'd1);
        tick();
        chk("t6_pulse", 32'(exit_pulse), 32'd1);
        repeat (8) tick();
        chk("t6_not_yet", 32'(exit_reject), 32'd0);
        tick();
        chk("t6_timeout", 32'(exit_reject), 32'd1);
        chk("t6_occ_kept", 32'(occupancy), 32'h2);
        tick();
        pulse_exit(2'd1);
        tick();
        tick();
        pay_ok = 1'b1;
        tick();
        pay_ok = 1'b0;
        chk("t6_gate_out", 32'(gate_out_open), 32'd1);
        tick();
        tick();
        #2 rst = 1'b1;
        #1 chk("t6_reset_mid", 32'(act_vec()), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
